// File: rtl/vga_pkg.sv
// Shared raster constants and helpers for the VGA timing generator.
// Holds the two supported video modes and the total-period helpers.
package vga_pkg;

  // 1280x1024@60, positive sync polarity (the generator defaults)
  localparam int   M1280_H_VIS = 1280;
  localparam int   M1280_H_FP  = 48;
  localparam int   M1280_H_SP  = 112;
  localparam int   M1280_H_BP  = 248;
  localparam logic M1280_H_POL = 1'b1;
  localparam int   M1280_V_VIS = 1024;
  localparam int   M1280_V_FP  = 1;
  localparam int   M1280_V_SP  = 3;
  localparam int   M1280_V_BP  = 38;
  localparam logic M1280_V_POL = 1'b1;

  // 640x480@60, 800x525 total, negative sync polarity
  localparam int   M640_H_VIS = 640;
  localparam int   M640_H_FP  = 16;
  localparam int   M640_H_SP  = 96;
  localparam int   M640_H_BP  = 48;
  localparam logic M640_H_POL = 1'b0;
  localparam int   M640_V_VIS = 480;
  localparam int   M640_V_FP  = 10;
  localparam int   M640_V_SP  = 2;
  localparam int   M640_V_BP  = 33;
  localparam logic M640_V_POL = 1'b0;

  function automatic int h_total(input int vis, input int fp, input int sp, input int bp);
    return vis + fp + sp + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sp, input int bp);
    return vis + fp + sp + bp;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register with a configurable reset value.
// DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int            DEPTH   = 1,
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          vgaClk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = ^{vgaClk, rst_n, ce};
      assign dout = din;
    end else begin : g_pipe
      logic [DW-1:0] stage [DEPTH];

      always_ff @(posedge vgaClk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (ce) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: a fetch-request coordinate stream plus display
// coordinates/syncs that trail it by LEAD enabled cycles.
import vga_pkg::*;

module vga_timing_gen #(
  parameter int   W       = 12,
  parameter int   H_VIS   = M1280_H_VIS,
  parameter int   H_FP    = M1280_H_FP,
  parameter int   H_SP    = M1280_H_SP,
  parameter int   H_BP    = M1280_H_BP,
  parameter logic H_POL   = M1280_H_POL,
  parameter int   V_VIS   = M1280_V_VIS,
  parameter int   V_FP    = M1280_V_FP,
  parameter int   V_SP    = M1280_V_SP,
  parameter int   V_BP    = M1280_V_BP,
  parameter logic V_POL   = M1280_V_POL,
  parameter int   LEAD    = 2,
  parameter int   FRAME_W = 8
) (
  input  logic               vgaClk,
  input  logic               rst_n,
  input  logic               ce,
  output logic [W-1:0]       req_x,
  output logic [W-1:0]       req_y,
  output logic               req_valid,
  output logic [W-1:0]       x,
  output logic [W-1:0]       y,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               sof,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = h_total(H_VIS, H_FP, H_SP, H_BP);
  localparam int V_TOTAL = v_total(V_VIS, V_FP, V_SP, V_BP);

  generate
    if (H_SP == 0 || V_SP == 0) begin : g_bad_sync
      $error("vga_timing_gen: sync pulse width must be non-zero");
    end
    if (64'(H_TOTAL) > (64'd1 << W) || 64'(V_TOTAL) > (64'd1 << W)) begin : g_bad_total
      $error("vga_timing_gen: total period does not fit in W bits");
    end
    if (LEAD < 0 || LEAD > 15) begin : g_bad_lead
      $error("vga_timing_gen: LEAD must be in 0..15");
    end
  endgenerate

  // Comparisons run one bit wider so a total of exactly 2^W still fits.
  localparam logic [W:0] H_LAST = (W+1)'(H_TOTAL - 1);
  localparam logic [W:0] V_LAST = (W+1)'(V_TOTAL - 1);
  localparam logic [W:0] H_VIS_L = (W+1)'(H_VIS);
  localparam logic [W:0] V_VIS_L = (W+1)'(V_VIS);
  localparam logic [W:0] H_SS = (W+1)'(H_VIS + H_FP);
  localparam logic [W:0] H_SE = (W+1)'(H_VIS + H_FP + H_SP - 1);
  localparam logic [W:0] V_SS = (W+1)'(V_VIS + V_FP);
  localparam logic [W:0] V_SE = (W+1)'(V_VIS + V_FP + V_SP - 1);

  logic [W-1:0]       h_cnt, v_cnt;
  logic [W:0]         h_ext, v_ext;
  logic               hs_raw, vs_raw, sof_raw, vis_raw;
  logic               hs_s1, vs_s1, sof_s1, sof_seen;
  logic [FRAME_W-1:0] fc_s1;

  assign h_ext   = {1'b0, h_cnt};
  assign v_ext   = {1'b0, v_cnt};
  assign vis_raw = (h_ext < H_VIS_L) && (v_ext < V_VIS_L);
  assign hs_raw  = (h_ext >= H_SS) && (h_ext <= H_SE);
  assign vs_raw  = (v_ext >= V_SS) && (v_ext <= V_SE);
  assign sof_raw = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge vgaClk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (ce) begin
      if (h_ext == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_ext == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // The first sof after reset opens frame 0, so only later ones advance the count.
  always_ff @(posedge vgaClk or negedge rst_n) begin
    if (!rst_n) begin
      req_x     <= '0;
      req_y     <= '0;
      req_valid <= 1'b0;
      hs_s1     <= ~H_POL;
      vs_s1     <= ~V_POL;
      sof_s1    <= 1'b0;
      sof_seen  <= 1'b0;
      fc_s1     <= '0;
    end else if (ce) begin
      req_x     <= h_cnt;
      req_y     <= v_cnt;
      req_valid <= vis_raw;
      hs_s1     <= hs_raw ? H_POL : ~H_POL;
      vs_s1     <= vs_raw ? V_POL : ~V_POL;
      sof_s1    <= sof_raw;
      if (sof_raw) begin
        sof_seen <= 1'b1;
        if (sof_seen) fc_s1 <= fc_s1 + 1'b1;
      end
    end
  end

  localparam int DW = 2*W + 4 + FRAME_W;
  localparam logic [DW-1:0] DLY_RST = {{(2*W){1'b0}}, 1'b0, ~H_POL, ~V_POL, 1'b0, {FRAME_W{1'b0}}};

  logic [DW-1:0] dly_in, dly_out;

  assign dly_in = {req_x, req_y, req_valid, hs_s1, vs_s1, sof_s1, fc_s1};

  vga_delay_line #(
    .DEPTH   (LEAD),
    .DW      (DW),
    .RST_VAL (DLY_RST)
  ) u_dly (
    .vgaClk (vgaClk),
    .rst_n  (rst_n),
    .ce     (ce),
    .din    (dly_in),
    .dout   (dly_out)
  );

  assign {x, y, de, hsync, vsync, sof, frame_cnt} = dly_out;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 14x7 toy raster, with one
// instance at LEAD=2 and a second at LEAD=0 sharing the same stimulus.
module tb_vga_timing_gen;

  localparam int W  = 12;
  localparam int FW = 2;

  logic          vgaClk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b1;
  logic [W-1:0]  req_x, req_y, x, y;
  logic          req_valid, de, hsync, vsync, sof;
  logic [FW-1:0] frame_cnt;
  logic [W-1:0]  req_x0, req_y0, x0, y0;
  logic          req_valid0, de0, hsync0, vsync0, sof0;
  logic [FW-1:0] frame_cnt0;

  always #5 vgaClk = ~vgaClk;

  vga_timing_gen #(
    .W(W), .H_VIS(8), .H_FP(2), .H_SP(2), .H_BP(2), .H_POL(1'b1),
    .V_VIS(4), .V_FP(1), .V_SP(1), .V_BP(1), .V_POL(1'b1),
    .LEAD(2), .FRAME_W(FW)
  ) dut (
    .vgaClk(vgaClk), .rst_n(rst_n), .ce(ce),
    .req_x(req_x), .req_y(req_y), .req_valid(req_valid),
    .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync),
    .sof(sof), .frame_cnt(frame_cnt)
  );

  vga_timing_gen #(
    .W(W), .H_VIS(8), .H_FP(2), .H_SP(2), .H_BP(2), .H_POL(1'b1),
    .V_VIS(4), .V_FP(1), .V_SP(1), .V_BP(1), .V_POL(1'b1),
    .LEAD(0), .FRAME_W(FW)
  ) dut_lead0 (
    .vgaClk(vgaClk), .rst_n(rst_n), .ce(ce),
    .req_x(req_x0), .req_y(req_y0), .req_valid(req_valid0),
    .x(x0), .y(y0), .de(de0), .hsync(hsync0), .vsync(vsync0),
    .sof(sof0), .frame_cnt(frame_cnt0)
  );

  typedef struct {
    logic [W-1:0]  rx, ry;
    logic          rv;
    logic [W-1:0]  x, y;
    logic          de, hs, vs, sf;
    logic [FW-1:0] fc;
    logic [W-1:0]  x0, y0;
    logic          de0, hs0, vs0, sf0;
    logic [FW-1:0] fc0;
  } exp_t;

  exp_t sb_q[$];
  exp_t last_exp, reset_exp, mon_e;
  int   hist_h[$], hist_v[$];
  int   rh, rv, disp_frames, req_frames;
  int   assertions = 0;
  int   failures = 0;

  // Hand-derived pixel properties for the 8/2/2/2 x 4/1/1/1 raster.
  function automatic void refPixel(input int h, input int v,
                                   output logic pde, output logic phs,
                                   output logic pvs, output logic psf);
    pde = (h < 8) && (v < 4);
    phs = (h == 10) || (h == 11);
    pvs = (v == 5);
    psf = (h == 0) && (v == 0);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] want);
    assertions++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("req_x", 32'(req_x), 32'(e.rx));
    cmp("req_y", 32'(req_y), 32'(e.ry));
    cmp("req_valid", 32'(req_valid), 32'(e.rv));
    cmp("x", 32'(x), 32'(e.x));
    cmp("y", 32'(y), 32'(e.y));
    cmp("de", 32'(de), 32'(e.de));
    cmp("hsync", 32'(hsync), 32'(e.hs));
    cmp("vsync", 32'(vsync), 32'(e.vs));
    cmp("sof", 32'(sof), 32'(e.sf));
    cmp("frame_cnt", 32'(frame_cnt), 32'(e.fc));
    cmp("lead0_x", 32'(x0), 32'(e.x0));
    cmp("lead0_y", 32'(y0), 32'(e.y0));
    cmp("lead0_req_x", 32'(req_x0), 32'(e.x0));
    cmp("lead0_de", 32'(de0), 32'(e.de0));
    cmp("lead0_req_valid", 32'(req_valid0), 32'(e.de0));
    cmp("lead0_hsync", 32'(hsync0), 32'(e.hs0));
    cmp("lead0_vsync", 32'(vsync0), 32'(e.vs0));
    cmp("lead0_sof", 32'(sof0), 32'(e.sf0));
    cmp("lead0_frame_cnt", 32'(frame_cnt0), 32'(e.fc0));
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic applyStimulus(input logic ce_val);
    exp_t e;
    int   ph, pv;
    ce = ce_val;
    @(posedge vgaClk);
    #1;
    if (!ce_val) begin
      e = last_exp;
    end else begin
      e = reset_exp;
      e.rx = W'(rh);
      e.ry = W'(rv);
      e.rv = (rh < 8) && (rv < 4);
      e.x0 = W'(rh);
      e.y0 = W'(rv);
      refPixel(rh, rv, e.de0, e.hs0, e.vs0, e.sf0);
      if (e.sf0) req_frames++;
      e.fc0 = FW'((req_frames - 1) % 4);
      hist_h.push_back(rh);
      hist_v.push_back(rv);
      if (hist_h.size() > 2) begin
        ph = hist_h.pop_front();
        pv = hist_v.pop_front();
        e.x = W'(ph);
        e.y = W'(pv);
        refPixel(ph, pv, e.de, e.hs, e.vs, e.sf);
        if (e.sf) disp_frames++;
        e.fc = FW'((disp_frames - 1) % 4);
      end
      rh++;
      if (rh == 14) begin
        rh = 0;
        rv++;
        if (rv == 7) rv = 0;
      end
    end
    last_exp = e;
    sb_q.push_back(e);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    ce = 1'b1;
    rh = 0;
    rv = 0;
    disp_frames = 0;
    req_frames = 0;
    hist_h.delete();
    hist_v.delete();
    last_exp = reset_exp;
    repeat (5) begin
      @(posedge vgaClk);
      #1;
      sb_q.push_back(reset_exp);
    end
    rst_n = 1'b1;
  endtask

  task automatic runUntil(input int tx, input int ty);
    int n = 0;
    while (!(last_exp.x == W'(tx) && last_exp.y == W'(ty) && last_exp.de)) begin
      if (n >= 300) begin
        assertions++;
        failures++;
        $display("[TB] FAIL run_until: display never reached (%0d,%0d)", tx, ty);
        return;
      end
      applyStimulus(1'b1);
      n++;
    end
  endtask

  always @(negedge vgaClk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checkOutput(mon_e);
    end
  end

  initial begin
    reset_exp = '{default: '0};
    last_exp = reset_exp;

    resetDut();
    repeat (500) applyStimulus(1'b1);

    runUntil(4, 1);
    repeat (3) applyStimulus(1'b0);
    repeat (20) applyStimulus(1'b1);

    runUntil(6, 2);
    @(negedge vgaClk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(reset_exp);
    resetDut();
    repeat (40) applyStimulus(1'b1);

    repeat (3) @(negedge vgaClk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
